// File: rtl/wbdbg_pkg.sv
// Shared definitions for the Wishbone debug transaction serializer:
// transaction field widths, framing constants and the frame FSM encoding.
package wbdbg_pkg;

  localparam int TIDBITS  = 13;
  localparam int ADDRBITS = 26;
  localparam int DATABITS = 16;

  // {tid, we, adr, dat_m, dat_s}
  localparam int DEF_BUSBITS = TIDBITS + 1 + ADDRBITS + 2 * DATABITS;

  localparam logic [7:0] DEF_SYNC  = 8'hA5;
  localparam logic [7:0] DROP_MASK = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  // Header byte: sync pattern, with the drop bit folded in when
  // transactions were lost ahead of this frame.
  function automatic logic [7:0] hdr_byte(input logic [7:0] sync, input logic flag);
    return flag ? (sync | DROP_MASK) : sync;
  endfunction

endpackage

// File: rtl/fsfifo.sv
// First-word-fall-through synchronous FIFO. Head entry is visible on
// data_o whenever empty_o is low; rd_i pops it.
module fsfifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             wr_en;
  logic             rd_en;

  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_en) rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/wbdbg_serializer.sv
// Buffers debug-monitor transactions and emits each as a framed byte
// packet (header, payload MSB first, XOR checksum) on a valid/ready port.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no frame in flight; waiting for a FIFO entry
// HDR     | header byte pending (first cycle after IDLE sets it up)
// DATA    | payload byte idx_q on the output
// CSUM    | checksum on the output; chains straight into next frame
module wbdbg_serializer
  import wbdbg_pkg::*;
#(
  parameter int         BUSBITS = DEF_BUSBITS,
  parameter int         DEPTH   = 16,
  parameter logic [7:0] SYNC    = DEF_SYNC
) (
  input  logic               i_wb_clk,
  input  logic               i_wb_rst,
  input  logic               i_dbg_stb,
  input  logic [BUSBITS-1:0] i_dbg_txn,
  output logic               o_byte_stb,
  output logic [7:0]         o_byte,
  input  logic               i_byte_rdy,
  output logic [7:0]         o_drop_cnt,
  output logic               o_busy
);

  localparam int         NB       = BUSBITS / 8;
  localparam logic [3:0] LAST_IDX = 4'(NB - 1);

  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_wr;
  logic               fifo_pop;
  logic [BUSBITS-1:0] fifo_head;
  logic               drop;
  logic               xfer;

  state_t             state_q;
  logic [BUSBITS-1:0] sreg_q;
  logic [3:0]         idx_q;
  logic [7:0]         csum_q;
  logic [7:0]         byte_q;
  logic               stb_q;
  logic               hdr_flag_q;
  logic               drop_flag_q;
  logic [7:0]         drop_cnt_q;

  assign xfer     = stb_q && i_byte_rdy;
  // Full check uses this cycle's flag, so a simultaneous pop never rescues a write.
  assign drop     = i_dbg_stb && fifo_full;
  assign fifo_wr  = i_dbg_stb && !fifo_full;
  assign fifo_pop = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_CSUM && xfer));

  assign o_byte_stb = stb_q;
  assign o_byte     = byte_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_busy     = !fifo_empty || (state_q != ST_IDLE);

  fsfifo #(
    .WIDTH (BUSBITS),
    .DEPTH (DEPTH)
  ) txnfifo (
    .clk_i   (i_wb_clk),
    .rst_i   (i_wb_rst),
    .wr_i    (fifo_wr),
    .data_i  (i_dbg_txn),
    .rd_i    (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Saturating drop counter and sticky drop flag; a drop on the load cycle wins over the clear.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      drop_cnt_q  <= 8'd0;
      drop_flag_q <= 1'b0;
    end else begin
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (drop)          drop_flag_q <= 1'b1;
      else if (fifo_pop) drop_flag_q <= 1'b0;
    end
  end

  // Frame FSM with registered byte/strobe; each state change also stages the next byte.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      idx_q      <= 4'd0;
      csum_q     <= 8'd0;
      byte_q     <= 8'd0;
      stb_q      <= 1'b0;
      hdr_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            sreg_q     <= fifo_head;
            hdr_flag_q <= drop_flag_q;
            csum_q     <= 8'd0;
            idx_q      <= 4'd0;
            state_q    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (!stb_q) begin
            stb_q  <= 1'b1;
            byte_q <= hdr_byte(SYNC, hdr_flag_q);
          end else if (i_byte_rdy) begin
            byte_q  <= sreg_q[BUSBITS-1 -: 8];
            idx_q   <= 4'd0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum_q <= csum_q ^ byte_q;
            sreg_q <= sreg_q << 8;
            if (idx_q == LAST_IDX) begin
              byte_q  <= csum_q ^ byte_q;
              state_q <= ST_CSUM;
            end else begin
              byte_q <= sreg_q[BUSBITS-9 -: 8];
              idx_q  <= idx_q + 4'd1;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            if (!fifo_empty) begin
              sreg_q     <= fifo_head;
              hdr_flag_q <= drop_flag_q;
              byte_q     <= hdr_byte(SYNC, drop_flag_q);
              csum_q     <= 8'd0;
              idx_q      <= 4'd0;
              state_q    <= ST_HDR;
            end else begin
              stb_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          stb_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbdbg_serializer.sv
// Scoreboard bench for wbdbg_serializer: stimulus pushes expected bytes,
// a negedge monitor pops and compares each transferred byte.
module tb_wbdbg_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [71:0] txn = '0;
  logic        rdy = 1'b1;
  logic        o_byte_stb;
  logic [7:0]  o_byte;
  logic [7:0]  o_drop_cnt;
  logic        o_busy;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit mark_first = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  int rdy_mode = 1;   // 0: held low, 1: held high, 2: toggle

  always #5 clk = ~clk;

  wbdbg_serializer #(.BUSBITS(72), .DEPTH(16), .SYNC(8'hA5)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_dbg_stb  (stb),
    .i_dbg_txn  (txn),
    .o_byte_stb (o_byte_stb),
    .o_byte     (o_byte),
    .i_byte_rdy (rdy),
    .o_drop_cnt (o_drop_cnt),
    .o_busy     (o_busy)
  );

  // Sink ready pattern
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rdy = 1'b0;
      2:       rdy = ~rdy;
      default: rdy = 1'b1;
    endcase
  end

  // Monitor: stall stability and scoreboard compare on every transfer
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!o_byte_stb || o_byte !== prev_byte) begin
          errors++;
          $display("FAIL stall_hold actual stb=%0b byte=%02h required stb=1 byte=%02h",
                   o_byte_stb, o_byte, prev_byte);
        end
      end
      if (o_byte_stb && rdy) begin
        xfer_cnt++;
        last_cyc = cyc;
        if (mark_first) begin
          first_cyc  = cyc;
          mark_first = 1'b0;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected actual=%02h required=none", o_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (o_byte !== e) begin
            errors++;
            $display("FAIL byte_seq actual=%02h required=%02h", o_byte, e);
          end
        end
      end
      prev_stall = o_byte_stb && !rdy;
      prev_byte  = o_byte;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic strobe(input logic [71:0] t);
    stb = 1'b1;
    txn = t;
    tick();
    stb = 1'b0;
  endtask

  task automatic push_frame(input logic [71:0] t, input logic flag);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(flag ? 8'hA7 : 8'hA5);
    for (int i = 0; i < 9; i++) begin
      b = t[71 - 8*i -: 8];
      cs ^= b;
      exp_q.push_back(b);
    end
    exp_q.push_back(cs);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    bit ok;
    n = 0;
    while ((exp_q.size() != 0 || o_busy || o_byte_stb) && n < budget) begin
      tick();
      n++;
    end
    ok = (exp_q.size() == 0) && !o_busy && !o_byte_stb;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d_bytes_left required=0 (timeout %0d cycles)",
               name, exp_q.size(), budget);
    end
  endtask

  initial begin
    int x0;
    logic [71:0] t;
    logic [7:0] hand[11];
    hand = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A, 8'h5A};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_stb",  {31'd0, o_byte_stb}, 32'd0);
    chk("rst_byte", {24'd0, o_byte}, 32'd0);
    chk("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Single transaction, hand-computed bytes, header latency
    foreach (hand[i]) exp_q.push_back(hand[i]);
    strobe(72'h0123_4567_89AB_CDEF_5A);
    chk("lat_n0", {31'd0, o_byte_stb}, 32'd0);
    tick();
    chk("lat_n1", {31'd0, o_byte_stb}, 32'd0);
    tick();
    chk("lat_n2_stb", {31'd0, o_byte_stb}, 32'd1);
    chk("lat_n2_hdr", {24'd0, o_byte}, 32'hA5);
    drain("single_drain", 40);

    // Backpressure: ready toggling every cycle
    rdy_mode = 2;
    push_frame(72'h0123_4567_89AB_CDEF_5A, 1'b0);
    strobe(72'h0123_4567_89AB_CDEF_5A);
    drain("bp_drain", 80);
    rdy_mode = 1;
    repeat (2) tick();

    // Back-to-back: three strobes, 33 consecutive byte cycles
    x0 = xfer_cnt;
    mark_first = 1'b1;
    push_frame(72'h11_2233_4455_6677_8899, 1'b0);
    push_frame(72'hFF_EEDD_CCBB_AA99_8877, 1'b0);
    push_frame(72'h00_0000_0000_0000_0001, 1'b0);
    stb = 1'b1;
    txn = 72'h11_2233_4455_6677_8899; tick();
    txn = 72'hFF_EEDD_CCBB_AA99_8877; tick();
    txn = 72'h00_0000_0000_0000_0001; tick();
    stb = 1'b0;
    drain("b2b_drain", 60);
    chk("b2b_count", xfer_cnt - x0, 32'd33);
    chk("b2b_span",  last_cyc - first_cyc, 32'd32);

    // Overflow: one frame stalled in flight, 16 fill the FIFO, 2 dropped
    rdy_mode = 0;
    tick();
    push_frame(72'hC0_FFEE_0000_1111_2222, 1'b0);
    strobe(72'hC0_FFEE_0000_1111_2222);
    repeat (3) tick();
    chk("ovf_stalled", {31'd0, o_byte_stb}, 32'd1);
    x0 = xfer_cnt;
    for (int i = 0; i < 18; i++) begin
      t = {8'h40 + 8'(i), 64'h0123_4567_0000_0000 | 64'(i * 3)};
      if (i < 16) push_frame(t, i == 0);
      stb = 1'b1;
      txn = t;
      tick();
    end
    stb = 1'b0;
    tick();
    chk("ovf_drops", {24'd0, o_drop_cnt}, 32'd2);
    chk("ovf_busy",  {31'd0, o_busy}, 32'd1);
    rdy_mode = 1;
    drain("ovf_drain", 17 * 11 + 40);
    chk("ovf_bytes", xfer_cnt - x0, 32'd187);

    // Drop counter saturation
    rdy_mode = 0;
    tick();
    strobe(72'h99_0000_0000_0000_0000);
    repeat (3) tick();
    stb = 1'b1;
    txn = 72'h55_5555_5555_5555_5555;
    repeat (316) tick();
    stb = 1'b0;
    tick();
    chk("sat_drops", {24'd0, o_drop_cnt}, 32'd255);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 1;
    chk("sat_rst_drops", {24'd0, o_drop_cnt}, 32'd0);
    chk("sat_rst_busy",  {31'd0, o_busy}, 32'd0);
    repeat (2) tick();

    // Reset right after payload byte 3 has transferred
    x0 = xfer_cnt;
    push_frame(72'hDE_ADBE_EF01_0203_0405, 1'b0);
    strobe(72'hDE_ADBE_EF01_0203_0405);
    repeat (7) tick();
    chk("mid_xfers", xfer_cnt - x0, 32'd5);
    rst = 1'b1;
    tick();
    chk("mid_rst_stb",  {31'd0, o_byte_stb}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();

    // Clean frame after mid-frame reset
    push_frame(72'h3C_A5A5_0F0F_F0F0_7E7E, 1'b0);
    strobe(72'h3C_A5A5_0F0F_F0F0_7E7E);
    tick();
    tick();
    chk("post_rst_hdr", {24'd0, o_byte}, 32'hA5);
    drain("post_rst_drain", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
